shared_add_server: RTL and testbench

//  Serves add requests from two independent requesters, A and B, on one shared
//  N-bit adder with a 2-stage pipeline.
//  It is the consumer side of a resource-sharing test: requesters issue

---
 rtl/share_pkg.sv | 18 +
 rtl/rr_arb2.sv | 33 +++
 rtl/shared_add_server.sv | 125 ++++++++++++
 tb/tb_shared_add_server.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/share_pkg.sv
// Shared types for the two-port add server.
// Port ids, the request operand bundle and the pipeline depth.
package share_pkg;

  localparam int SHARE_N = 4;
  localparam int LATENCY = 2;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  typedef struct packed {
    logic [SHARE_N-1:0] op_a;
    logic [SHARE_N-1:0] op_b;
  } add_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// The pointer moves past the winner only when a grant is taken.
module rr_arb2
  import share_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_id_t ptr;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = (ptr == PORT_A) ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PORT_A;
    end else if (advance) begin
      ptr <= gnt[0] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/shared_add_server.sv
// Two requesters share one adder through a 2-stage pipeline.
// Each port keeps at most one request outstanding until its result is taken.
module shared_add_server
  import share_pkg::*;
#(
  parameter int N = SHARE_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_reqA_valid,
  input  logic [N-1:0] IN_reqA_opA,
  input  logic [N-1:0] IN_reqA_opB,
  output logic         OUT_reqA_ready,
  input  logic         IN_reqB_valid,
  input  logic [N-1:0] IN_reqB_opA,
  input  logic [N-1:0] IN_reqB_opB,
  output logic         OUT_reqB_ready,
  output logic         OUT_resA_valid,
  output logic [N:0]   OUT_resA_sum,
  input  logic         IN_resA_ready,
  output logic         OUT_resB_valid,
  output logic [N:0]   OUT_resB_sum,
  input  logic         IN_resB_ready
);

  logic         live;
  logic         busy_a;
  logic         busy_b;
  logic         rdy_a;
  logic         rdy_b;
  logic [1:0]   req;
  logic [1:0]   gnt;
  logic         fire;
  logic         s1_vld;
  port_id_t     s1_id;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic [N:0]   sum;
  logic         res_a_vld;
  logic         res_b_vld;
  logic [N:0]   res_a_sum;
  logic [N:0]   res_b_sum;
  logic         done_a;
  logic         done_b;

  // live keeps ready low until the first edge after reset release
  assign rdy_a = live & ~busy_a;
  assign rdy_b = live & ~busy_b;
  assign req   = {IN_reqB_valid & rdy_b, IN_reqA_valid & rdy_a};
  assign fire  = |gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (fire),
    .gnt     (gnt)
  );

  assign sum    = {1'b0, s1_a} + {1'b0, s1_b};
  assign done_a = res_a_vld & IN_resA_ready;
  assign done_b = res_b_vld & IN_resB_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live   <= 1'b0;
      busy_a <= 1'b0;
      busy_b <= 1'b0;
    end else begin
      live <= 1'b1;
      if (gnt[0]) busy_a <= 1'b1;
      else if (done_a) busy_a <= 1'b0;
      if (gnt[1]) busy_b <= 1'b1;
      else if (done_b) busy_b <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_id  <= PORT_A;
      s1_a   <= '0;
      s1_b   <= '0;
    end else begin
      s1_vld <= fire;
      if (fire) begin
        s1_id <= gnt[1] ? PORT_B : PORT_A;
        s1_a  <= gnt[1] ? IN_reqB_opA : IN_reqA_opA;
        s1_b  <= gnt[1] ? IN_reqB_opB : IN_reqA_opB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_a_vld <= 1'b0;
      res_a_sum <= '0;
      res_b_vld <= 1'b0;
      res_b_sum <= '0;
    end else begin
      if (done_a) begin
        res_a_vld <= 1'b0;
        res_a_sum <= '0;
      end else if (s1_vld && s1_id == PORT_A) begin
        res_a_vld <= 1'b1;
        res_a_sum <= sum;
      end
      if (done_b) begin
        res_b_vld <= 1'b0;
        res_b_sum <= '0;
      end else if (s1_vld && s1_id == PORT_B) begin
        res_b_vld <= 1'b1;
        res_b_sum <= sum;
      end
    end
  end

  assign OUT_reqA_ready = rdy_a;
  assign OUT_reqB_ready = rdy_b;
  assign OUT_resA_valid = res_a_vld;
  assign OUT_resA_sum   = res_a_sum;
  assign OUT_resB_valid = res_b_vld;
  assign OUT_resB_sum   = res_b_sum;

endmodule

// File: tb/tb_shared_add_server.sv
// Bench for shared_add_server: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_shared_add_server;
  import share_pkg::*;

  localparam int N = SHARE_N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic va = 1'b0;
  logic vb = 1'b0;
  logic rra = 1'b0;
  logic rrb = 1'b0;
  add_req_t qa = '0;
  add_req_t qb = '0;
  logic rdy_a, rdy_b, rv_a, rv_b;
  logic [N:0] rs_a, rs_b;

  always #5 clk = ~clk;

  shared_add_server #(.N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_reqA_valid  (va),
    .IN_reqA_opA    (qa.op_a),
    .IN_reqA_opB    (qa.op_b),
    .OUT_reqA_ready (rdy_a),
    .IN_reqB_valid  (vb),
    .IN_reqB_opA    (qb.op_a),
    .IN_reqB_opB    (qb.op_b),
    .OUT_reqB_ready (rdy_b),
    .OUT_resA_valid (rv_a),
    .OUT_resA_sum   (rs_a),
    .IN_resA_ready  (rra),
    .OUT_resB_valid (rv_b),
    .OUT_resB_sum   (rs_b),
    .IN_resB_ready  (rrb)
  );

  typedef struct {
    int port;
    int sum;
    int due;
  } fl_t;

  int n_cmp = 0;
  int n_err = 0;
  int cnt = 0;
  bit m_live = 0;
  bit m_busy [2];
  bit m_rv [2];
  int m_rs [2];
  bit m_last_b = 1;
  fl_t fl [$];
  bit f_a, f_b;
  int fires [2];
  int rises [2];
  bit pv [2];
  int rq [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_live = 0;
    m_busy[0] = 0; m_busy[1] = 0;
    m_rv[0] = 0;   m_rv[1] = 0;
    m_rs[0] = 0;   m_rs[1] = 0;
    m_last_b = 1;
    fl.delete();
    pv[0] = 0;     pv[1] = 0;
  endtask

  // Advance one clock: predict the edge, then compare at the next negedge.
  task automatic cyc();
    bit ra, rb;
    bit ga, gb;
    ra = m_live && !m_busy[0];
    rb = m_live && !m_busy[1];
    ga = 0;
    gb = 0;
    if (va && ra && vb && rb) begin
      if (m_last_b) ga = 1;
      else gb = 1;
    end else begin
      ga = va && ra;
      gb = vb && rb;
    end
    f_a = ga;
    f_b = gb;
    @(posedge clk);
    if (m_rv[0] && rra) begin
      m_rv[0] = 0; m_rs[0] = 0; m_busy[0] = 0;
    end
    if (m_rv[1] && rrb) begin
      m_rv[1] = 0; m_rs[1] = 0; m_busy[1] = 0;
    end
    if (ga) begin
      m_busy[0] = 1;
      m_last_b = 0;
      fires[0]++;
      fl.push_back('{0, int'(qa.op_a) + int'(qa.op_b), cnt + LATENCY});
    end
    if (gb) begin
      m_busy[1] = 1;
      m_last_b = 1;
      fires[1]++;
      fl.push_back('{1, int'(qb.op_a) + int'(qb.op_b), cnt + LATENCY});
    end
    cnt++;
    while (fl.size() > 0 && fl[0].due == cnt) begin
      m_rv[fl[0].port] = 1;
      m_rs[fl[0].port] = fl[0].sum;
      void'(fl.pop_front());
    end
    m_live = 1;
    @(negedge clk);
    chk("rdyA", rdy_a, m_live && !m_busy[0]);
    chk("rdyB", rdy_b, m_live && !m_busy[1]);
    chk("resA_v", rv_a, m_rv[0]);
    chk("resB_v", rv_b, m_rv[1]);
    chk("resA_s", rs_a, m_rs[0]);
    chk("resB_s", rs_b, m_rs[1]);
    if (rv_a && !pv[0]) begin rises[0]++; rq.push_back(0); end
    if (rv_b && !pv[1]) begin rises[1]++; rq.push_back(1); end
    pv[0] = rv_a;
    pv[1] = rv_b;
  endtask

  task automatic do_reset(int hold);
    va = 0; vb = 0; rra = 0; rrb = 0;
    rst = 0;
    #1;
    chk("rst_rdyA", rdy_a, 0);
    chk("rst_rdyB", rdy_b, 0);
    chk("rst_resA_v", rv_a, 0);
    chk("rst_resB_v", rv_b, 0);
    chk("rst_resA_s", rs_a, 0);
    chk("rst_resB_s", rs_b, 0);
    model_clear();
    repeat (hold) begin
      @(negedge clk);
      chk("rst_hold_A", rv_a, 0);
      chk("rst_hold_B", rv_b, 0);
    end
    rst = 1;
    cyc();
  endtask

  task automatic new_a(int x, int y);
    va = 1; qa.op_a = x[N-1:0]; qa.op_b = y[N-1:0];
  endtask

  task automatic new_b(int x, int y);
    vb = 1; qb.op_a = x[N-1:0]; qb.op_b = y[N-1:0];
  endtask

  initial begin
    #2;
    do_reset(2);

    // lone request, carry out
    rra = 1;
    new_a(7, 9);
    cyc();
    va = 0;
    chk("t1_rdy_c1", rdy_a, 0);
    cyc();
    chk("t1_v_c2", rv_a, 1);
    chk("t1_sum", rs_a, 5'b10000);
    chk("t1_rdy_c2", rdy_a, 0);
    cyc();
    chk("t1_rdy_c3", rdy_a, 1);

    // contention straight after reset
    do_reset(1);
    rra = 1; rrb = 1;
    new_a(3, 4);
    new_b(15, 15);
    cyc();
    chk("t2_firstA", f_a, 1);
    va = 0;
    cyc();
    chk("t2_nextB", f_b, 1);
    vb = 0;
    chk("t2_sumA", rs_a, 7);
    cyc();
    chk("t2_sumB", rs_b, 30);
    cyc();

    // back-pressure on B while A keeps flowing
    rrb = 0; rra = 1;
    new_b(1, 2);
    cyc();
    vb = 0;
    for (int i = 0; i < 6; i++) begin
      if (!va) new_a(i + 5, i);
      cyc();
      if (f_a) va = 0;
    end
    chk("t3_hold_v", rv_b, 1);
    chk("t3_hold_s", rs_b, 3);
    chk("t3_rdyB", rdy_b, 0);
    chk("t3_A_done", rises[0] >= 2, 1);
    rrb = 1;
    va = 0;
    repeat (4) cyc();

    // fairness with both ports always requesting
    rq.delete();
    rra = 1; rrb = 1;
    new_a(1, 1);
    new_b(2, 2);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (f_a) new_a($urandom_range(0, 15), $urandom_range(0, 15));
      if (f_b) new_b($urandom_range(0, 15), $urandom_range(0, 15));
    end
    chk("t4_count", rq.size() >= 8, 1);
    for (int i = 1; i < rq.size(); i++)
      chk("t4_alt", rq[i] != rq[i-1], 1);
    va = 0; vb = 0;
    repeat (4) cyc();

    // reset one cycle after an A handshake
    rra = 1;
    new_a(9, 9);
    cyc();
    chk("t5_fired", f_a, 1);
    va = 0;
    do_reset(2);
    chk("t5_noresA", rv_a, 0);
    chk("t5_rdyA", rdy_a, 1);
    rra = 1;
    new_a(0, 0);
    cyc();
    va = 0;
    cyc();
    chk("t5_zero_v", rv_a, 1);
    chk("t5_zero_s", rs_a, 0);
    cyc();

    // random traffic against the model
    fires[0] = 0; fires[1] = 0;
    rises[0] = 0; rises[1] = 0;
    for (int i = 0; i < 400; i++) begin
      if (!va && $urandom_range(0, 2) != 0)
        new_a($urandom_range(0, 15), $urandom_range(0, 15));
      if (!vb && $urandom_range(0, 2) != 0)
        new_b($urandom_range(0, 15), $urandom_range(0, 15));
      rra = ($urandom_range(0, 3) != 0);
      rrb = ($urandom_range(0, 3) != 0);
      cyc();
      if (f_a) va = 0;
      if (f_b) vb = 0;
    end
    va = 0; vb = 0; rra = 1; rrb = 1;
    repeat (6) cyc();
    chk("t6_cntA", rises[0], fires[0]);
    chk("t6_cntB", rises[1], fires[1]);
    chk("t6_busy", fires[0] > 20 && fires[1] > 20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
